// File: rtl/pipe_front_ctrl_pkg.sv
// Shared constants for the front-end pipeline controller: FSM state encodings,
// the NOP instruction word and the PC increment helper.
package pipe_front_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] StHold = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StKill = 2'd2;

    // Adding 4 never carries into bits [1:0], so they pass through unchanged.
    function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter; only present when PIPE_PERF_CNT_EN is defined.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipe_front_ctrl.sv
// Front-end controller: PC register, imem request handshake, IF/ID register and
// ID/EX valid bit. PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_front_ctrl
    import pipe_front_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_en_i,
    input  logic            if_id_stall_i,
    input  logic            if_id_flush_i,
    input  logic            id_ex_flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            if_id_valid_o,
    output logic            id_ex_valid_o,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o,
`endif
    output logic            fetch_busy_o
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            id_ex_valid_q, id_ex_valid_d;
    logic            capture;
    logic            redir_apply;
    logic            if_id_flush;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        capture     = 1'b0;
        redir_apply = 1'b0;
        case (state_q)
            StHold: state_d = StRun;
            StRun: begin
                if (imem_ready_i) begin
                    if (redirect_i) begin
                        pc_d        = redirect_pc_i;
                        redir_apply = 1'b1;
                    end else if (pc_en_i) begin
                        pc_d    = pc_incr(pc_q);
                        capture = 1'b1;
                    end
                end else if (redirect_i) begin
                    pend_pc_d = redirect_pc_i;
                    state_d   = StKill;
                end
            end
            StKill: begin
                // A redirect arriving with the stale response still wins.
                if (imem_ready_i) begin
                    pc_d        = redirect_i ? redirect_pc_i : pend_pc_q;
                    redir_apply = 1'b1;
                    state_d     = StRun;
                end else if (redirect_i) begin
                    pend_pc_d = redirect_pc_i;
                end
            end
            default: state_d = StHold;
        endcase
    end

    assign if_id_flush = if_id_flush_i | redir_apply;

    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (if_id_flush) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (if_id_stall_i) begin
            if_id_valid_d = if_id_valid_q;
        end else if (capture) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem_rdata_i;
            if_id_pc_d    = pc_q;
        end else begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end
        id_ex_valid_d = id_ex_flush_i ? 1'b0 : if_id_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StHold;
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            if_id_pc_q    <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            id_ex_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            id_ex_valid_q <= id_ex_valid_d;
        end
    end

    assign imem_req_o    = (state_q != StHold);
    assign imem_addr_o   = pc_q;
    assign fetch_busy_o  = imem_req_o & ~imem_ready_i;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;
    assign id_ex_valid_o = id_ex_valid_q;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt #(
        .Width (32)
    ) u_stall_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (~pc_en_i | fetch_busy_o),
        .cnt_o  (stall_cnt_o)
    );

    pipe_perf_cnt #(
        .Width (32)
    ) u_flush_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (if_id_flush),
        .cnt_o  (flush_cnt_o)
    );
`endif

endmodule
